// File: rtl/bb_sram_arbiter.sv
// Round-robin arbiter sharing one BB SRAM port among N requesters; one single-word access at a time.
// Latency: bb_en_o one cycle after a request in IDLE, ack_o the cycle after; requesters hold req_i until ack_o.
module bb_sram_arbiter #(
    parameter int N  = 2,
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic            bb_clk_i,
    input  logic            bb_rst_ni,
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    we_i,
    input  logic [N*AW-1:0] addr_i,
    input  logic [N*DW-1:0] din_i,
    output logic [N-1:0]    gnt_o,
    output logic [N-1:0]    ack_o,
    output logic [DW-1:0]   dout_o,
    output logic [AW-1:0]   bb_addr_o,
    output logic [DW-1:0]   bb_din_o,
    output logic            bb_en_o,
    output logic            bb_we_o,
    input  logic [DW-1:0]   bb_dout_i
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t         r_state;
    logic [IW-1:0]  r_owner;
    logic [IW-1:0]  r_last;
    logic [N-1:0]   r_gnt;
    logic [N-1:0]   r_ack;
    logic           r_en;
    logic           r_we;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_din;

    logic [N-1:0]   w_cand;
    logic           w_found;
    logic           w_found_hi;
    logic [IW-1:0]  w_win_hi;
    logic [IW-1:0]  w_win_lo;
    logic [IW-1:0]  w_win;
    logic [N-1:0]   w_win_oh;
    logic           w_we;
    logic [AW-1:0]  w_addr;
    logic [DW-1:0]  w_din;

    // The owner's request seen during ACK is the one being acknowledged, never a new one.
    always_comb begin
        w_cand = req_i;
        if (r_state == ACK) begin
            w_cand[r_owner] = 1'b0;
        end
    end

    // Lowest candidate above the last winner, else lowest candidate overall (wrap).
    always_comb begin
        w_found    = |w_cand;
        w_found_hi = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_win_lo = IW'(i);
                if (IW'(i) > r_last) begin
                    w_found_hi = 1'b1;
                    w_win_hi   = IW'(i);
                end
            end
        end
        w_win = w_found_hi ? w_win_hi : w_win_lo;
    end

    always_comb begin
        w_win_oh = '0;
        w_we     = 1'b0;
        w_addr   = '0;
        w_din    = '0;
        for (int i = 0; i < N; i++) begin
            if (w_win == IW'(i)) begin
                w_win_oh[i] = 1'b1;
                w_we        = we_i[i];
                w_addr      = addr_i[i*AW +: AW];
                w_din       = din_i[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge bb_clk_i or negedge bb_rst_ni) begin
        if (!bb_rst_ni) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_last  <= IW'(N - 1);
            r_gnt   <= '0;
            r_ack   <= '0;
            r_en    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
        end else begin
            case (r_state)
                ACCESS: begin
                    r_state <= ACK;
                    r_en    <= 1'b0;
                    r_we    <= 1'b0;
                    r_ack   <= r_gnt;
                end
                default: begin
                    // IDLE and ACK share arbitration so ACK can chain straight into the next ACCESS.
                    r_ack <= '0;
                    if (w_found) begin
                        r_state <= ACCESS;
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_gnt   <= w_win_oh;
                        r_en    <= 1'b1;
                        r_we    <= w_we;
                        r_addr  <= w_addr;
                        r_din   <= w_din;
                    end else begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign gnt_o     = r_gnt;
    assign ack_o     = r_ack;
    assign bb_en_o   = r_en;
    assign bb_we_o   = r_we;
    assign bb_addr_o = r_addr;
    assign bb_din_o  = r_din;
    assign dout_o    = (r_state == ACK) ? bb_dout_i : '0;

endmodule
